line_refill_ctrl: RTL and testbench
===================================

LINE_REFILL_CTRL -- requirements
Module: line_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per cache line (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port miss_valid  input  1  data cache requests a line refill; held until accepted.
REQ-005 SHALL have port miss_ready  output  1  block can accept a refill request.
REQ-006 SHALL have port miss_addr  input  32  byte address of the missing access.
REQ-007 SHALL have port victim_dirty  input  1  evicted line must be written back first.
REQ-008 SHALL have port victim_addr  input  32  line-aligned byte address of the victim line.
REQ-009 SHALL have port victim_data  input  32*LINE_WORDS  victim line; word i in bits [32i+31:32i].
REQ-010 SHALL have port fill_we  output  1  write fill_data into cache line word fill_idx.
REQ-011 SHALL have port fill_idx  output  $clog2(LINE_WORDS)  word index within the line.
REQ-012 SHALL have port fill_data  output  32  refill word.
REQ-013 SHALL have port fill_done  output  1  one-cycle pulse: refill complete, cache may release its stall.
REQ-014 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32): the single-word backing-memory request.
REQ-015 SHALL have ports mem_ack (input, 1), mem_rdata (input, 32): request completion; read data is valid in the ack cycle.

Function
REQ-016 SHALL implement states IDLE, WB, FILL and DONE.
REQ-017 SHALL drive miss_ready=1 only in IDLE.
REQ-018 SHALL accept a request when miss_valid and miss_ready are both 1, registering miss_addr, victim_addr, victim_data and victim_dirty in that cycle.
REQ-019 SHALL go IDLE->WB on acceptance when victim_dirty=1, otherwise IDLE->FILL.
REQ-020 WB SHALL issue LINE_WORDS writes: mem_we=1, word i to victim_addr+4i, data = word i of the captured victim_data.
REQ-021 FILL SHALL issue LINE_WORDS reads (mem_we=0) from line base = miss_addr with its low log2(LINE_WORDS*4) bits cleared.
REQ-022 SHALL hold mem_req=1 with mem_addr, mem_wdata and mem_we stable until mem_ack=1.
REQ-023 SHALL present the next word, or change state, in the cycle after an ack; mem_ack in the first request cycle is legal.
REQ-024 SHALL ignore mem_ack while mem_req=0.
REQ-025 SHALL keep a word counter that wraps LINE_WORDS-1->0 on the final ack of each phase.
REQ-026 WB->FILL SHALL occur on the last write ack.
REQ-027 On each read ack, SHALL assert fill_we in the next cycle, with fill_idx equal to the acked word index and fill_data equal to the registered mem_rdata.
REQ-028 The last read ack SHALL cause FILL->DONE.
REQ-029 DONE SHALL assert fill_done=1 for exactly one cycle, coinciding with the final fill_we, then go to IDLE.
REQ-030 Zero-wait memory latency SHALL be: clean miss accepted at T, reads at T+1..T+LINE_WORDS, fill_done at T+LINE_WORDS+1; a dirty miss adds LINE_WORDS cycles.
REQ-031 miss_valid asserted during DONE SHALL not be accepted until the following IDLE cycle.

Reset
REQ-032 On rst=0, SHALL asynchronously enter IDLE and clear the counter and all captured registers.
REQ-033 On rst=0, SHALL set miss_ready=0 while rst=0, miss_ready=1 after release, and mem_req, mem_we, fill_we, fill_done=0, with mem_addr, mem_wdata, fill_idx and fill_data=0.
REQ-034 Reset mid-WB or mid-FILL SHALL abandon the transaction, with no further fill_we and no fill_done for it.

Configuration
REQ-035 With macro CRITICAL_WORD_FIRST_EN defined, FILL SHALL start at the word index of miss_addr, increment modulo LINE_WORDS (wrapping past LINE_WORDS-1 to 0), and issue exactly LINE_WORDS reads.
REQ-036 Without CRITICAL_WORD_FIRST_EN, FILL SHALL always start at word 0; WB order SHALL be 0..LINE_WORDS-1 in both builds.

Verification
REQ-037 Clean miss, LINE_WORDS=4, miss_addr=0x0000_1008, mem_ack every request cycle -> reads 0x1000,0x1004,0x1008,0x100C; fill_idx 0..3; fill_done at T+5.
REQ-038 Dirty miss, victim_addr=0x2000, victim_data words A0..A3 -> writes to 0x2000..0x200C with data A0..A3, then 4 reads; fill_done at T+9.
REQ-039 mem_ack delayed 3 cycles per word -> mem_addr and mem_wdata stable throughout each wait; fill_we count=4; fill_done exactly once.
REQ-040 CRITICAL_WORD_FIRST_EN build, miss_addr=0x100C -> read order 0x100C,0x1000,0x1004,0x1008; fill_idx order 3,0,1,2.
REQ-041 rst=0 asserted after the second read ack, then released -> all outputs 0 immediately; no fill_done; miss_ready=1 after release; next request proceeds normally.
REQ-042 miss_valid held high through DONE -> second request accepted only in the IDLE cycle after fill_done; spurious mem_ack while mem_req=0 causes no state change.

Source files
------------

// File: rtl/line_refill_ctrl.sv
// line_refill_ctrl
// Cache line refill controller. It accepts one miss at a time, writes back a
// dirty victim line word by word, then reads the missing line from backing
// memory one word per request and streams each word into the cache array.
//
// Optional build macro: CRITICAL_WORD_FIRST_EN
//   undefined : the fill always starts at word 0 of the line.
//   defined   : the fill starts at the word that missed, then wraps modulo
//               LINE_WORDS.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   miss_valid/miss_ready    refill request handshake
//   miss_addr                byte address of the missing access
//   victim_dirty/addr/data   victim line; it is written back first when dirty
//   fill_we/idx/data         one cache-line word write per read ack
//   fill_done                one-cycle pulse that coincides with the last fill_we
//   mem_req/we/addr/wdata    single-word backing-memory request, held until ack
//   mem_ack/mem_rdata        request completion; rdata is valid in the ack cycle
module line_refill_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [31:0]                   miss_addr,
  input  logic                          victim_dirty,
  input  logic [31:0]                   victim_addr,
  input  logic [32*LINE_WORDS-1:0]      victim_data,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [31:0]                   fill_data,
  output logic                          fill_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata
);

  localparam int IDXW = $clog2(LINE_WORDS);
  localparam int OFFW = IDXW + 2;  // byte-offset bits within a line

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  state_t                    state_q;
  logic [IDXW-1:0]           cnt_q;          // words completed in the current phase
  logic [31-OFFW:0]          line_q;         // line number of the missing access
  logic [31:0]               victim_addr_q;
  logic [32*LINE_WORDS-1:0]  victim_data_q;
  logic                      miss_ready_q;
  logic                      mem_req_q;
  logic                      mem_we_q;
  logic [31:0]               mem_addr_q;
  logic [31:0]               mem_wdata_q;
  logic                      fill_we_q;
  logic [IDXW-1:0]           fill_idx_q;
  logic [31:0]               fill_data_q;
  logic                      fill_done_q;

  logic [IDXW-1:0] cnt_d;          // counter value after an ack; wraps on its own
  logic            cnt_last;
  logic [IDXW-1:0] acc_start_idx;  // first fill word for a request being accepted
  logic [IDXW-1:0] rd_idx_first;   // first fill word once the line is captured
  logic [IDXW-1:0] rd_idx_cur;     // word index of the read in flight
  logic [IDXW-1:0] rd_idx_nxt;     // word index of the following read

  assign cnt_d    = cnt_q + IDXW'(1);
  assign cnt_last = (cnt_q == IDXW'(LINE_WORDS - 1));

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDXW-1:0] start_q;
  logic            unused_addr_bits;
  assign acc_start_idx    = miss_addr[OFFW-1:2];
  assign rd_idx_first     = start_q;
  // IDXW-bit additions wrap modulo LINE_WORDS because it is a power of two
  assign rd_idx_cur       = cnt_q + start_q;
  assign rd_idx_nxt       = cnt_d + start_q;
  assign unused_addr_bits = ^miss_addr[1:0];
`else
  logic unused_addr_bits;
  assign acc_start_idx    = '0;
  assign rd_idx_first     = '0;
  assign rd_idx_cur       = cnt_q;
  assign rd_idx_nxt       = cnt_d;
  assign unused_addr_bits = ^miss_addr[OFFW-1:0];
`endif

  function automatic logic [31:0] rd_addr(input logic [31-OFFW:0] line,
                                          input logic [IDXW-1:0]  idx);
    return {line, idx, 2'b00};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      line_q        <= '0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      miss_ready_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fill_we_q     <= 1'b0;
      fill_idx_q    <= '0;
      fill_data_q   <= '0;
      fill_done_q   <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q       <= '0;
`endif
    end else begin
      // fill_we and fill_done are single-cycle pulses
      fill_we_q   <= 1'b0;
      fill_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          miss_ready_q <= 1'b1;
          if (miss_valid && miss_ready_q) begin
            miss_ready_q  <= 1'b0;
            line_q        <= miss_addr[31:OFFW];
            victim_addr_q <= victim_addr;
            victim_data_q <= victim_data;
`ifdef CRITICAL_WORD_FIRST_EN
            start_q       <= acc_start_idx;
`endif
            cnt_q         <= '0;
            mem_req_q     <= 1'b1;
            // The first request goes out in the cycle right after acceptance
            if (victim_dirty) begin
              state_q     <= S_WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= victim_addr;
              mem_wdata_q <= victim_data[31:0];
            end else begin
              state_q     <= S_FILL;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= rd_addr(miss_addr[31:OFFW], acc_start_idx);
              mem_wdata_q <= '0;
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            if (cnt_last) begin
              cnt_q       <= '0;
              state_q     <= S_FILL;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              mem_addr_q  <= rd_addr(line_q, rd_idx_first);
            end else begin
              cnt_q       <= cnt_d;
              mem_addr_q  <= victim_addr_q + {{(30-IDXW){1'b0}}, cnt_d, 2'b00};
              mem_wdata_q <= victim_data_q[32*cnt_d +: 32];
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            fill_we_q   <= 1'b1;
            fill_idx_q  <= rd_idx_cur;
            fill_data_q <= mem_rdata;
            if (cnt_last) begin
              cnt_q       <= '0;
              state_q     <= S_DONE;
              mem_req_q   <= 1'b0;
              fill_done_q <= 1'b1;  // lands together with the final fill_we
            end else begin
              cnt_q      <= cnt_d;
              mem_addr_q <= rd_addr(line_q, rd_idx_nxt);
            end
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          miss_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign miss_ready = miss_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign fill_we    = fill_we_q;
  assign fill_idx   = fill_idx_q;
  assign fill_data  = fill_data_q;
  assign fill_done  = fill_done_q;

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Testbench for line_refill_ctrl: the driver pushes the expected memory
// requests, fill writes and fill_done timing for each accepted miss into
// queues; a separate monitor pops and compares whenever the DUT shows them.
module tb_line_refill_ctrl;

  localparam int LW   = 4;
  localparam int IDXW = $clog2(LW);

  logic              clk;
  logic              rst;
  logic              miss_valid;
  logic              miss_ready;
  logic [31:0]       miss_addr;
  logic              victim_dirty;
  logic [31:0]       victim_addr;
  logic [32*LW-1:0]  victim_data;
  logic              fill_we;
  logic [IDXW-1:0]   fill_idx;
  logic [31:0]       fill_data;
  logic              fill_done;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  line_refill_ctrl #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .fill_done(fill_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_op_t;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [31:0]     data;
  } fill_t;

  mem_op_t exp_mem[$];
  fill_t   exp_fill[$];
  int      exp_done[$];   // expected fill_done cycle, -1 when latency is not fixed

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  int rd_ack_cnt = 0;
  int fixed_wait = 0;
  bit rand_wait = 1'b0;
  bit spurious_en = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Backing-memory contents: a fixed hash of the word address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: what one accepted miss must produce
  task automatic push_model(input logic [31:0] a, input logic d, input logic [31:0] va,
                            input logic [32*LW-1:0] vd, input int acc);
    int          start;
    int          idx;
    logic [31:0] base;
    logic [31:0] wa;
    mem_op_t     op;
    fill_t       f;
    if (d) begin
      for (int i = 0; i < LW; i++) begin
        op.we    = 1'b1;
        op.addr  = va + 32'(4 * i);
        op.wdata = vd[32*i +: 32];
        exp_mem.push_back(op);
      end
    end
    base = a & ~32'(LW * 4 - 1);
`ifdef CRITICAL_WORD_FIRST_EN
    start = int'((a >> 2) % LW);
`else
    start = 0;
`endif
    for (int k = 0; k < LW; k++) begin
      idx      = (start + k) % LW;
      wa       = base + 32'(4 * idx);
      op.we    = 1'b0;
      op.addr  = wa;
      op.wdata = 32'h0;
      exp_mem.push_back(op);
      f.idx  = IDXW'(idx);
      f.data = mem_f(wa);
      exp_fill.push_back(f);
    end
    if (fixed_wait == 0 && !rand_wait)
      exp_done.push_back(acc + LW + 1 + (d ? LW : 0));
    else
      exp_done.push_back(-1);
  endtask

  // Memory responder: acks after a per-request wait, spurious acks when idle
  initial begin
    int waited;
    int target;
    mem_ack = 1'b0;
    mem_rdata = '0;
    waited = 0;
    target = 0;
    forever begin
      @(negedge clk);
      if (rst && mem_req) begin
        if (waited == 0) target = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
        if (waited >= target) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_f(mem_addr);
          waited    = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          waited++;
        end
      end else begin
        waited    = 0;
        mem_ack   = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit          prev_wait;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    mem_op_t     op;
    fill_t       f;
    int          e;
    prev_wait = 1'b0;
    prev_we = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          chk("hold_mem_req", 64'(mem_req), 64'd1);
          chk("hold_mem_addr", 64'(mem_addr), 64'(prev_addr));
          chk("hold_mem_wdata", 64'(mem_wdata), 64'(prev_wdata));
          chk("hold_mem_we", 64'(mem_we), 64'(prev_we));
        end
        if (mem_req && mem_ack) begin
          if (!mem_we) rd_ack_cnt++;
          chk("mem_op_expected", 64'(exp_mem.size() != 0), 64'd1);
          if (exp_mem.size() != 0) begin
            op = exp_mem.pop_front();
            chk("mem_we", 64'(mem_we), 64'(op.we));
            chk("mem_addr", 64'(mem_addr), 64'(op.addr));
            if (op.we) chk("mem_wdata", 64'(mem_wdata), 64'(op.wdata));
          end
        end
        if (fill_we) begin
          chk("fill_expected", 64'(exp_fill.size() != 0), 64'd1);
          if (exp_fill.size() != 0) begin
            f = exp_fill.pop_front();
            chk("fill_idx", 64'(fill_idx), 64'(f.idx));
            chk("fill_data", 64'(fill_data), 64'(f.data));
          end
        end
        if (fill_done) begin
          chk("done_with_last_fill_we", 64'(fill_we), 64'd1);
          chk("fills_left_at_done", 64'(exp_fill.size()), 64'd0);
          chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
          if (exp_done.size() != 0) begin
            e = exp_done.pop_front();
            if (e >= 0) chk("done_latency", 64'(cyc), 64'(e));
          end
          last_done_cyc = cyc;
          $display("refill complete at cycle %0d", cyc);
        end
        prev_wait  = mem_req && !mem_ack;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
      end
    end
  end

  task automatic do_miss(input logic [31:0] a, input logic d, input logic [31:0] va,
                         input logic [32*LW-1:0] vd, input bit keep, input bit chk_b2b);
    int n;
    bit acc;
    @(negedge clk);
    miss_valid   = 1'b1;
    miss_addr    = a;
    victim_dirty = d;
    victim_addr  = va;
    victim_data  = vd;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      if (miss_ready) acc = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("accept_in_time", 64'(acc), 64'd1);
    if (acc) begin
      push_model(a, d, va, vd, cyc);
      if (chk_b2b) chk("b2b_accept_cycle", 64'(cyc), 64'(last_done_cyc + 1));
      @(negedge clk);
      miss_valid = keep;
    end else begin
      miss_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_done.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("refill_finished", 64'(exp_done.size()), 64'd0);
  endtask

  function automatic logic [32*LW-1:0] rand_line();
    logic [32*LW-1:0] v;
    for (int i = 0; i < LW; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [32*LW-1:0] vd;
    int n;
    rst = 1'b1;
    miss_valid = 1'b0;
    miss_addr = '0;
    victim_dirty = 1'b0;
    victim_addr = '0;
    victim_data = '0;
    #2 rst = 1'b0;
    #10;
    chk("rst_miss_ready", 64'(miss_ready), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_fill_we", 64'(fill_we), 64'd0);
    chk("rst_fill_done", 64'(fill_done), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_fill_data", 64'(fill_data), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(miss_ready), 64'd1);

    // Clean miss, zero-wait memory
    do_miss(32'h0000_1008, 1'b0, 32'h0, '0, 1'b0, 1'b0);
    wait_done();

    // Dirty miss, victim words A0..A3
    vd = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    do_miss(32'h0000_4018, 1'b1, 32'h0000_2000, vd, 1'b0, 1'b0);
    wait_done();

    // Three wait cycles per word: request fields must stay put while waiting
    fixed_wait = 3;
    do_miss(32'h0000_5024, 1'b1, 32'h0000_6040, rand_line(), 1'b0, 1'b0);
    wait_done();
    fixed_wait = 0;

    // Miss on the last word of a line
    do_miss(32'h0000_100C, 1'b0, 32'h0, '0, 1'b0, 1'b0);
    wait_done();

    // Reset after the second read ack abandons the refill
    rd_ack_cnt = 0;
    do_miss(32'h0000_3004, 1'b0, 32'h0, '0, 1'b0, 1'b0);
    n = 0;
    while (rd_ack_cnt < 2 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("second_read_ack_seen", 64'(rd_ack_cnt >= 2), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_mem_we", 64'(mem_we), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("midrst_fill_we", 64'(fill_we), 64'd0);
    chk("midrst_fill_idx", 64'(fill_idx), 64'd0);
    chk("midrst_fill_data", 64'(fill_data), 64'd0);
    chk("midrst_fill_done", 64'(fill_done), 64'd0);
    chk("midrst_miss_ready", 64'(miss_ready), 64'd0);
    exp_mem.delete();
    exp_fill.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after_release", 64'(miss_ready), 64'd1);
    repeat (4) @(negedge clk);
    do_miss(32'h0000_3004, 1'b1, 32'h0000_7000, rand_line(), 1'b0, 1'b0);
    wait_done();

    // miss_valid held through DONE: second request waits for the next IDLE cycle
    do_miss(32'h0000_8010, 1'b0, 32'h0, '0, 1'b1, 1'b0);
    do_miss(32'h0000_9028, 1'b1, 32'h0000_A000, rand_line(), 1'b0, 1'b1);
    wait_done();

    // Randomized misses with random or zero memory wait
    for (int t = 0; t < 24; t++) begin
      rand_wait = 1'($urandom_range(0, 1));
      do_miss($urandom, 1'($urandom_range(0, 1)), $urandom & ~32'(LW * 4 - 1),
              rand_line(), 1'b0, 1'b0);
      wait_done();
    end
    rand_wait = 1'b0;

    repeat (10) @(negedge clk);
    chk("leftover_mem_ops", 64'(exp_mem.size()), 64'd0);
    chk("leftover_fills", 64'(exp_fill.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
